codec_config_sequencer: RTL and testbench



---
 rtl/codec_config_sequencer.sv | 145 ++++++++++++++
 tb/tb_codec_config_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_config_sequencer.sv
// Power-up register sequencer for the WM8731 codec: walks a fixed table and issues one
// 24-bit I2C write per entry through i2c_controller, retrying NACKed writes.
module codec_config_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         INIT_DELAY  = 1000,
  parameter int         GAP_CYCLES  = 16,
  parameter int         MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reconfig,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
);

  localparam int CNT_MAX = (INIT_DELAY > GAP_CYCLES) ? INIT_DELAY : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    S_INIT, S_START, S_ARM, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_retry;
  logic             r_ack;
  logic [23:0]      w_word;
  logic             w_init_end;
  logic             w_gap_end;

  // Table word is {reg[6:0], val[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = {7'h0F, 9'h000};
      4'd1:    table_word = {7'h00, 9'h017};
      4'd2:    table_word = {7'h01, 9'h017};
      4'd3:    table_word = {7'h02, 9'h079};
      4'd4:    table_word = {7'h03, 9'h079};
      4'd5:    table_word = {7'h04, 9'h012};
      4'd6:    table_word = {7'h05, 9'h000};
      4'd7:    table_word = {7'h06, 9'h000};
      4'd8:    table_word = {7'h07, 9'h042};
      4'd9:    table_word = {7'h08, 9'h000};
      4'd10:   table_word = {7'h09, 9'h001};
      default: table_word = 16'h0000;
    endcase
  endfunction

  assign w_word     = {DEV_ADDR, table_word(cfg_index)};
  assign w_init_end = (r_cnt == CNT_W'(INIT_DELAY - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(GAP_CYCLES - 1));

  // Starts are also held back while a transfer left over from before reset is still running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_ack     <= 1'b0;
      i2c_start <= 1'b0;
      i2c_data  <= 24'h000000;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      cfg_index <= 4'd0;
    end else begin
      i2c_start <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (w_init_end && i2c_done) begin
            r_state   <= S_START;
            i2c_start <= 1'b1;
            i2c_data  <= w_word;
            r_cnt     <= '0;
          end else if (!w_init_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_START: r_state <= S_ARM;
        S_ARM: begin
          if (!i2c_done) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_done) begin
            r_ack   <= i2c_ack;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_ack) begin
            if (cfg_index == LAST_IDX) begin
              r_state  <= S_DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              cfg_index <= cfg_index + 4'd1;
              r_retry   <= '0;
              r_cnt     <= '0;
              r_state   <= S_GAP;
            end
          end else if (r_retry < RTY_W'(MAX_RETRIES)) begin
            r_retry <= r_retry + RTY_W'(1);
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_state   <= S_ERROR;
            cfg_busy  <= 1'b0;
            cfg_error <= 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_end && i2c_done) begin
            r_state   <= S_START;
            i2c_start <= 1'b1;
            i2c_data  <= w_word;
            r_cnt     <= '0;
          end else if (!w_gap_end) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERROR: begin
          if (reconfig) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_retry   <= '0;
            cfg_index <= 4'd0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: an I2C responder model with scripted NACKs and a
// scoreboard queue of expected write words, plus reconfig and async-reset sequences.
module tb_codec_config_sequencer;

  localparam int INIT_DELAY  = 100;
  localparam int GAP_CYCLES  = 16;
  localparam int MAX_RETRIES = 3;
  localparam int LAT         = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reconfig = 1'b0;
  logic        i2c_done = 1'b1;
  logic        i2c_ack = 1'b0;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [3:0]  cfg_index;

  always #5 clk = ~clk;

  codec_config_sequencer #(
    .DEV_ADDR(8'h34), .INIT_DELAY(INIT_DELAY), .GAP_CYCLES(GAP_CYCLES), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .reset(reset), .reconfig(reconfig),
    .i2c_start(i2c_start), .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .cfg_index(cfg_index)
  );

  typedef struct {
    int         nack_entry;
    int         nack_count;
    int         exp_starts;
    logic       exp_done;
    logic       exp_err;
    logic [3:0] exp_idx;
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] exp_word [11];
  logic [23:0] sq [$];
  int checks = 0, errors = 0, cyc = 0, n_starts = 0, rel_cyc = 0, done_cyc = 0;
  int nack_entry = -1, nack_left = 0;
  logic first = 1'b1, chk_stable = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder model and start-pulse monitor; all sampling on the falling edge.
  task automatic monitor();
    logic        prev_start = 1'b0;
    logic        busy = 1'b0;
    logic        ackv = 1'b0;
    int          lat = 0;
    logic [23:0] cur = '0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (i2c_start) begin
        check("start_width", 32'(prev_start), 32'd0);
        check("start_while_busy", 32'(i2c_done), 32'd1);
        n_starts++;
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got data %h, expected no start", i2c_data);
        end else begin
          e = sq.pop_front();
          check("i2c_data", 32'(i2c_data), 32'(e));
        end
        if (first) check("init_delay", 32'(cyc - rel_cyc), 32'(INIT_DELAY));
        else       check("gap_len", 32'(cyc - done_cyc), 32'(GAP_CYCLES + 2));
        first = 1'b0;
        cur  = i2c_data;
        ackv = 1'b1;
        if (nack_entry >= 0 && nack_left > 0 && cur == exp_word[nack_entry]) begin
          ackv = 1'b0;
          nack_left--;
        end
        busy = 1'b1;
        lat = LAT;
        i2c_done = 1'b0;
        chk_stable = 1'b1;
      end else if (busy) begin
        if (chk_stable) check("data_stable", 32'(i2c_data), 32'(cur));
        lat--;
        if (lat == 0) begin
          busy = 1'b0;
          i2c_done = 1'b1;
          i2c_ack = ackv;
          done_cyc = cyc;
        end
      end
      prev_start = i2c_start;
    end
  endtask

  task automatic push_expected(input int ne, input int nc);
    int att;
    sq.delete();
    for (int e = 0; e < 11; e++) begin
      att = (e == ne) ? nc + 1 : 1;
      if (att > MAX_RETRIES + 1) begin
        for (int k = 0; k < MAX_RETRIES + 1; k++) sq.push_back(exp_word[e]);
        break;
      end
      for (int k = 0; k < att; k++) sq.push_back(exp_word[e]);
    end
  endtask

  task automatic reset_run(input int ne, input int nc);
    @(negedge clk); #1;
    chk_stable = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    n_starts = 0;
    first = 1'b1;
    nack_entry = ne;
    nack_left = nc;
    push_expected(ne, nc);
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic reconfig_run(input int ne, input int nc);
    @(negedge clk); #1;
    n_starts = 0;
    first = 1'b1;
    nack_entry = ne;
    nack_left = nc;
    push_expected(ne, nc);
    rel_cyc = cyc + 1;
    reconfig = 1'b1;
    @(negedge clk); #1;
    reconfig = 1'b0;
    check("rcfg_done_drop", 32'(cfg_done), 32'd0);
    check("rcfg_err_drop", 32'(cfg_error), 32'd0);
    check("rcfg_busy", 32'(cfg_busy), 32'd1);
    check("rcfg_index", 32'(cfg_index), 32'd0);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(cfg_done || cfg_error)) begin
      checks++;
      errors++;
      $display("FAIL timeout_end: got busy=%0d after %0d cycles, expected done or error", cfg_busy, n);
    end
  endtask

  task automatic wait_starts(input int cnt, input int budget);
    int n = 0;
    while (n_starts < cnt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_starts < cnt) begin
      checks++;
      errors++;
      $display("FAIL timeout_starts: got %0d starts, expected %0d", n_starts, cnt);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, 32'(i2c_start), 32'd0);
    check({tag, "_data"}, 32'(i2c_data), 32'd0);
    check({tag, "_busy"}, 32'(cfg_busy), 32'd1);
    check({tag, "_done"}, 32'(cfg_done), 32'd0);
    check({tag, "_error"}, 32'(cfg_error), 32'd0);
    check({tag, "_index"}, 32'(cfg_index), 32'd0);
  endtask

  initial begin
    int s;
    exp_word = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                 24'h340A00, 24'h340C00, 24'h340E42, 24'h341000, 24'h341201};
    vecs[0] = '{-1, 0,  11, 1'b1, 1'b0, 4'd10};
    vecs[1] = '{3,  1,  12, 1'b1, 1'b0, 4'd10};
    vecs[2] = '{10, 3,  14, 1'b1, 1'b0, 4'd10};
    vecs[3] = '{0,  4,  4,  1'b0, 1'b1, 4'd0};
    vecs[4] = '{7,  99, 11, 1'b0, 1'b1, 4'd7};
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("por");

    foreach (vecs[i]) begin
      reset_run(vecs[i].nack_entry, vecs[i].nack_count);
      wait_end(6000);
      check("done", 32'(cfg_done), 32'(vecs[i].exp_done));
      check("error", 32'(cfg_error), 32'(vecs[i].exp_err));
      check("busy_end", 32'(cfg_busy), 32'd0);
      check("index_end", 32'(cfg_index), 32'(vecs[i].exp_idx));
      check("start_count", 32'(n_starts), 32'(vecs[i].exp_starts));
      check("queue_left", 32'(sq.size()), 32'd0);
      if (vecs[i].exp_err) begin
        s = n_starts;
        repeat (200) @(negedge clk);
        #1;
        check("no_start_after_err", 32'(n_starts), 32'(s));
        check("err_held", 32'(cfg_error), 32'd1);
        check("index_frozen", 32'(cfg_index), 32'(vecs[i].exp_idx));
      end
    end

    // Reconfig out of ERROR, then out of DONE with an ignored mid-run pulse.
    reconfig_run(-1, 0);
    wait_end(6000);
    check("rcfg_err_done", 32'(cfg_done), 32'd1);
    check("rcfg_err_starts", 32'(n_starts), 32'd11);
    check("rcfg_err_index", 32'(cfg_index), 32'd10);

    reconfig_run(-1, 0);
    wait_starts(3, 2000);
    @(negedge clk); #1;
    reconfig = 1'b1;
    @(negedge clk); #1;
    reconfig = 1'b0;
    check("midrun_busy", 32'(cfg_busy), 32'd1);
    wait_end(6000);
    check("midrun_done", 32'(cfg_done), 32'd1);
    check("midrun_starts", 32'(n_starts), 32'd11);
    check("midrun_queue", 32'(sq.size()), 32'd0);

    // Async reset while waiting on entry 4's transfer.
    reset_run(-1, 0);
    wait_starts(5, 2000);
    check("wait_index", 32'(cfg_index), 32'd4);
    repeat (5) @(negedge clk);
    #2;
    chk_stable = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    @(negedge clk); #1;
    n_starts = 0;
    first = 1'b1;
    push_expected(-1, 0);
    reset = 1'b0;
    rel_cyc = cyc;
    wait_end(6000);
    check("after_rst_done", 32'(cfg_done), 32'd1);
    check("after_rst_starts", 32'(n_starts), 32'd11);
    check("after_rst_index", 32'(cfg_index), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
